// File: rtl/mult_pkg.sv
// Shared definitions for the iterative 64x64 multiplier.
package mult_pkg;
  localparam int WIDTH = 64;
  localparam int CNT_W = 7;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mult_state_t;
endpackage

// File: rtl/addSub64.sv
// Execute-stage add/subtract unit; sub selects a - b (with carryIn=1 for two's complement).
module addSub64 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             carryIn,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut
);

  logic [WIDTH-1:0] b_eff;

  // Full-width add with carry-out on the optionally inverted second operand.
  always_comb begin
    b_eff             = sub ? ~b : b;
    {carryOut, sum}   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carryIn};
  end

endmodule

// File: rtl/mult_step.sv
// One radix-2 shift-and-add iteration over the {hi, lo} product register pair.
module mult_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] s;
  logic             c;

  // Add the multiplicand only when the current multiplier bit is set.
  always_comb addend = lo[0] ? mcand : '0;

  addSub64 #(.WIDTH(WIDTH)) u_add (
    .a        (hi),
    .b        (addend),
    .sub      (1'b0),
    .carryIn  (1'b0),
    .sum      (s),
    .carryOut (c)
  );

  // Shift the 129-bit {c, s, lo} right by one; the carry lands in the top of hi.
  always_comb begin
    next_hi = {c, s[WIDTH-1:1]};
    next_lo = {s[0], lo[WIDTH-1:1]};
  end

endmodule

// File: rtl/mult64_seq.sv
// Sequential unsigned multiplier: FSM, iteration counter and product registers.
module mult64_seq #(
  parameter int WIDTH = mult_pkg::WIDTH,
  parameter int CNT_W = mult_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] product_hi,
  output logic             zero
);

  import mult_pkg::*;

  mult_state_t      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] step_hi, step_lo;

  mult_step #(.WIDTH(WIDTH)) u_step (
    .hi      (hi_q),
    .lo      (lo_q),
    .mcand   (mcand_q),
    .next_hi (step_hi),
    .next_lo (step_lo)
  );

  // State and datapath registers; reset takes priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      zero_q  <= zero_d;
    end
  end

  // Next-state logic: load on accepted start, iterate WIDTH times, pulse done.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          lo_d    = b;
          hi_d    = '0;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        hi_d    = step_hi;
        lo_d    = step_lo;
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          zero_d  = ({step_hi, step_lo} == '0);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ready      = (state_q == IDLE);
  assign done       = (state_q == DONE);
  assign product_lo = lo_q;
  assign product_hi = hi_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_mult64_seq.sv
// Self-checking bench for mult64_seq: cycle-level reference model plus directed literals.
module tb_mult64_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] a, b;
  logic        ready, done, zero;
  logic [63:0] product_lo, product_hi;

  int total = 0;
  int bad   = 0;

  mult64_seq #(.WIDTH(64), .CNT_W(7)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .a          (a),
    .b          (b),
    .ready      (ready),
    .done       (done),
    .product_lo (product_lo),
    .product_hi (product_hi),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: phase counts cycles since the accepting edge (0 = idle,
  // 65 = the done cycle); the result is plain 128-bit multiplication.
  int           phase = 0;
  logic [127:0] m_pending = '0;
  logic [127:0] m_res = '0;
  logic         m_zero = 1'b0;
  logic         chk_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      phase <= 0;
      m_res <= '0;
      m_zero <= 1'b0;
    end else if (phase == 0) begin
      if (start) begin
        phase     <= 1;
        m_pending <= {64'b0, a} * {64'b0, b};
      end
    end else if (phase == 64) begin
      phase  <= 65;
      m_res  <= m_pending;
      m_zero <= (m_pending == '0);
    end else if (phase == 65) begin
      phase <= 0;
    end else begin
      phase <= phase + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", {127'b0, ready}, {127'b0, phase == 0});
      check("done", {127'b0, done}, {127'b0, phase == 65});
      if (phase == 0 || phase == 65) begin
        check("product", {product_hi, product_lo}, m_res);
        check("zero", {127'b0, zero}, {127'b0, m_zero});
      end
    end
  end

  task automatic op(input logic [63:0] x, input logic [63:0] y);
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
  endtask

  // Edges after the accepting edge until done is seen; noisy start/operands while busy.
  task automatic wait_done(input bit noise, output int n);
    n = 0;
    while (!done && n < 200) begin
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
      end
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    if (!done) check("timeout", {127'b0, done}, 128'd1);
  endtask

  initial begin
    int n;
    logic [63:0] x, y;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_ready", {127'b0, ready}, 128'd1);
    check("rst_prod", {product_hi, product_lo}, 128'd0);

    // 3 x 5
    op(64'd3, 64'd5);
    check("busy_e1", {127'b0, ready}, 128'd0);
    wait_done(1'b0, n);
    check("latency", 128'(n), 128'd64);
    check("p3x5_lo", {64'b0, product_lo}, 128'd15);
    check("p3x5_hi", {64'b0, product_hi}, 128'd0);
    check("p3x5_zero", {127'b0, zero}, 128'd0);
    @(posedge clk);
    #1;
    check("ready_after", {127'b0, ready}, 128'd1);
    check("done_once", {127'b0, done}, 128'd0);

    // zero product
    op(64'd0, 64'hDEADBEEF);
    wait_done(1'b0, n);
    check("zero_flag", {127'b0, zero}, 128'd1);
    @(posedge clk);
    #1;

    // all-ones squared exercises carry into product_hi
    op('1, '1);
    wait_done(1'b0, n);
    check("ones_hi", {64'b0, product_hi}, {64'b0, 64'hFFFF_FFFF_FFFF_FFFE});
    check("ones_lo", {64'b0, product_lo}, 128'd1);
    @(posedge clk);
    #1;

    // 2^63 * 2
    op(64'h8000_0000_0000_0000, 64'd2);
    wait_done(1'b0, n);
    check("p63_hi", {64'b0, product_hi}, 128'd1);
    check("p63_lo", {64'b0, product_lo}, 128'd0);
    @(posedge clk);
    #1;

    // start held high: operands change mid-run, next accept 66 edges after E0
    a = 64'h1111;
    b = 64'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 64'h22;
    b = 64'd2;
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("held_lat", 128'(n), 128'd64);
    check("held_prod", {product_hi, product_lo}, 128'h3333);
    @(posedge clk);
    #1;
    check("held_e65", {127'b0, ready}, 128'd1);
    @(posedge clk);
    #1;
    check("held_e66", {127'b0, ready}, 128'd0);
    start = 1'b0;
    wait_done(1'b0, n);
    check("held_prod2", {product_hi, product_lo}, 128'h44);
    @(posedge clk);
    #1;

    // reset at E30 aborts the run
    op(64'hABCD, 64'h1234);
    repeat (29) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_ready", {127'b0, ready}, 128'd1);
    check("abort_prod", {product_hi, product_lo}, 128'd0);
    repeat (40) begin
      @(posedge clk);
      #1;
    end
    op(64'd7, 64'd9);
    wait_done(1'b0, n);
    check("p7x9", {product_hi, product_lo}, 128'd63);
    @(posedge clk);
    #1;

    // product hold while idle
    op(64'h1234, 64'h10);
    wait_done(1'b0, n);
    repeat (100) begin
      @(posedge clk);
      #1;
    end
    check("hold_prod", {product_hi, product_lo}, 128'h12340);
    check("hold_zero", {127'b0, zero}, 128'd0);

    // randomized operands with noisy start/operands during the run
    for (int i = 0; i < 25; i++) begin
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      if (i % 5 == 1) x = '0;
      if (i % 7 == 2) y = 64'(1) << $urandom_range(0, 63);
      op(x, y);
      wait_done(1'b1, n);
      check("rand_lat", 128'(n), 128'd64);
      repeat ($urandom_range(1, 3)) begin
        @(posedge clk);
        #1;
      end
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
